// File: rtl/pipeline6_fetch_redirect_pkg.sv
// rtl/pipeline6_fetch_redirect_pkg.sv - shared PC-select codes and opcode constants
// Purpose: definitions shared by the fetch/redirect block and the branch unit.
// Contents: pc_sel_e select codes, opcode[6:2] constants, is_redirect() helper.
package pipeline6_fetch_redirect_pkg;

  typedef enum logic [2:0] {
    PCSEL_SEQ   = 3'd0,
    PCSEL_IMMF  = 3'd1,
    PCSEL_ALUX  = 3'd2,
    PCSEL_BR_T  = 3'd3,
    PCSEL_BR_NT = 3'd4
  } pc_sel_e;

  // opcode[6:2] major classes, decoded identically by the branch unit
  localparam logic [4:0] OPC_LOAD  = 5'b00000;
  localparam logic [4:0] OPC_I     = 5'b00100;
  localparam logic [4:0] OPC_AUIPC = 5'b00101;
  localparam logic [4:0] OPC_S     = 5'b01000;
  localparam logic [4:0] OPC_R     = 5'b01100;
  localparam logic [4:0] OPC_LUI   = 5'b01101;
  localparam logic [4:0] OPC_B     = 5'b11000;
  localparam logic [4:0] OPC_JALR  = 5'b11001;
  localparam logic [4:0] OPC_JAL   = 5'b11011;

  // Corrective redirects: JALR target and both D2 branch outcomes.
  // A sequential or F-stage predicted jump is not a correction.
  function automatic logic is_redirect(input logic [2:0] sel);
    return (sel == PCSEL_ALUX) || (sel == PCSEL_BR_T) || (sel == PCSEL_BR_NT);
  endfunction

endpackage

// File: rtl/pipeline6_pc_target.sv
// rtl/pipeline6_pc_target.sv - combinational next-PC target mux with error flags
// Purpose: form the next fetch address from the select code.
// Ports:
//   i_pc_sel    in  3   select code
//   i_pcF       in  32  current fetch PC
//   i_pcD2      in  32  PC of branch in D2
//   i_immF      in  32  J/B immediate of F instruction
//   i_immD2     in  32  B immediate of D2 branch
//   i_alu_x     in  32  JALR target from X
//   o_target    out 32  aligned target ([1:0] forced to 00)
//   o_misalign  out 1   raw target had [1:0]!=0
//   o_sel_bad   out 1   select code 5..7
//   o_redirect  out 1   select code is a corrective redirect
module pipeline6_pc_target
  import pipeline6_fetch_redirect_pkg::*;
(
  input  logic [2:0]  i_pc_sel,
  input  logic [31:0] i_pcF,
  input  logic [31:0] i_pcD2,
  input  logic [31:0] i_immF,
  input  logic [31:0] i_immD2,
  input  logic [31:0] i_alu_x,
  output logic [31:0] o_target,
  output logic        o_misalign,
  output logic        o_sel_bad,
  output logic        o_redirect
);

  logic [31:0] w_raw;

  always_comb begin
    w_raw     = i_pcF + 32'd4;
    o_sel_bad = 1'b0;
    case (i_pc_sel)
      PCSEL_SEQ:   w_raw = i_pcF + 32'd4;
      PCSEL_IMMF:  w_raw = i_pcF + i_immF;
      PCSEL_ALUX:  w_raw = i_alu_x & ~32'd1;
      PCSEL_BR_T:  w_raw = i_pcD2 + i_immD2;
      PCSEL_BR_NT: w_raw = i_pcD2 + 32'd4;
      default: begin
        // unknown codes fall back to sequential fetch
        w_raw     = i_pcF + 32'd4;
        o_sel_bad = 1'b1;
      end
    endcase
  end

  assign o_target   = {w_raw[31:2], 2'b00};
  assign o_misalign = |w_raw[1:0];
  assign o_redirect = is_redirect(i_pc_sel);

endmodule

// File: rtl/pipeline6_fetch_redirect.sv
// rtl/pipeline6_fetch_redirect.sv - fetch PC register and F/D/D2/X valid tracking
// Purpose: applies PC-select codes and kill requests each cycle, tracks PCs to X.
// Ports:
//   i_clk, i_rst                  clock, synchronous active-high reset
//   i_stall                       hold F/D, bubble into D2
//   i_pc_sel                      next-PC select code
//   i_killD/D2/X_req              invalidate instruction entering that stage
//   i_immF, i_immD2, i_alu_x      target operands
//   o_pcF/o_pcD/o_pcD2/o_pcX      stage PCs
//   o_validF/D/D2/X               stage valid bits
//   o_redirect_cnt                saturating corrective-redirect count
//   o_misalign_err, o_sel_err     sticky error flags
module pipeline6_fetch_redirect
  import pipeline6_fetch_redirect_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_stall,
  input  logic [2:0]       i_pc_sel,
  input  logic             i_killD_req,
  input  logic             i_killD2_req,
  input  logic             i_killX_req,
  input  logic [31:0]      i_immF,
  input  logic [31:0]      i_immD2,
  input  logic [31:0]      i_alu_x,
  output logic [31:0]      o_pcF,
  output logic [31:0]      o_pcD,
  output logic [31:0]      o_pcD2,
  output logic [31:0]      o_pcX,
  output logic             o_validF,
  output logic             o_validD,
  output logic             o_validD2,
  output logic             o_validX,
  output logic [CNT_W-1:0] o_redirect_cnt,
  output logic             o_misalign_err,
  output logic             o_sel_err
);

  logic [31:0]      r_pcF, r_pcD, r_pcD2, r_pcX;
  logic             r_validF, r_validD, r_validD2, r_validX;
  logic [CNT_W-1:0] r_redirect_cnt;
  logic             r_misalign_err, r_sel_err;

  logic [31:0] w_target;
  logic        w_misalign, w_sel_bad, w_redirect, w_advance;

  pipeline6_pc_target u_target (
    .i_pc_sel   (i_pc_sel),
    .i_pcF      (r_pcF),
    .i_pcD2     (r_pcD2),
    .i_immF     (i_immF),
    .i_immD2    (i_immD2),
    .i_alu_x    (i_alu_x),
    .o_target   (w_target),
    .o_misalign (w_misalign),
    .o_sel_bad  (w_sel_bad),
    .o_redirect (w_redirect)
  );

  // A redirect overrides a stall: the wrong-path instructions held in F/D are
  // retired by the accompanying kills, so F/D must move on.
  assign w_advance = w_redirect | ~i_stall;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pcF          <= RESET_PC;
      r_pcD          <= 32'd0;
      r_pcD2         <= 32'd0;
      r_pcX          <= 32'd0;
      r_validF       <= 1'b0;
      r_validD       <= 1'b0;
      r_validD2      <= 1'b0;
      r_validX       <= 1'b0;
      r_redirect_cnt <= '0;
      r_misalign_err <= 1'b0;
      r_sel_err      <= 1'b0;
    end else begin
      // fetch always has something in flight once out of reset
      r_validF <= 1'b1;
      // D2 -> X moves every cycle, stalled or not
      r_pcX    <= r_pcD2;
      r_validX <= r_validD2 & ~i_killX_req;
      if (w_advance) begin
        r_pcF     <= w_target;
        r_pcD     <= r_pcF;
        r_pcD2    <= r_pcD;
        r_validD  <= r_validF & ~i_killD_req;
        r_validD2 <= r_validD & ~i_killD2_req;
        // only a target actually loaded into F counts as misaligned
        if (w_misalign) r_misalign_err <= 1'b1;
      end else begin
        r_validD2 <= 1'b0;
      end
      if (w_redirect && (r_redirect_cnt != {CNT_W{1'b1}}))
        r_redirect_cnt <= r_redirect_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      if (w_sel_bad) r_sel_err <= 1'b1;
    end
  end

  assign o_pcF          = r_pcF;
  assign o_pcD          = r_pcD;
  assign o_pcD2         = r_pcD2;
  assign o_pcX          = r_pcX;
  assign o_validF       = r_validF;
  assign o_validD       = r_validD;
  assign o_validD2      = r_validD2;
  assign o_validX       = r_validX;
  assign o_redirect_cnt = r_redirect_cnt;
  assign o_misalign_err = r_misalign_err;
  assign o_sel_err      = r_sel_err;

endmodule

// File: tb/tb_pipeline6_fetch_redirect.sv
// tb/tb_pipeline6_fetch_redirect.sv - directed scoreboard bench for pipeline6_fetch_redirect
module tb_pipeline6_fetch_redirect;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst, stall, kd, kd2, kx;
  logic [2:0]    pc_sel;
  logic [31:0]   immF, immD2, alu_x;
  logic [31:0]   pcF, pcD, pcD2, pcX;
  logic          vF, vD, vD2, vX, mis_err, sel_err;
  logic [CW-1:0] cnt;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [31:0]   pcF, pcD, pcD2, pcX;
    logic [3:0]    v;      // {F, D, D2, X}
    logic [CW-1:0] cnt;
    logic          mis, sel;
  } exp_t;

  exp_t m;
  exp_t sb[$];

  always #5 clk = ~clk;

  pipeline6_fetch_redirect #(.RESET_PC(32'h100), .CNT_W(CW)) dut (
    .i_clk(clk), .i_rst(rst), .i_stall(stall), .i_pc_sel(pc_sel),
    .i_killD_req(kd), .i_killD2_req(kd2), .i_killX_req(kx),
    .i_immF(immF), .i_immD2(immD2), .i_alu_x(alu_x),
    .o_pcF(pcF), .o_pcD(pcD), .o_pcD2(pcD2), .o_pcX(pcX),
    .o_validF(vF), .o_validD(vD), .o_validD2(vD2), .o_validX(vX),
    .o_redirect_cnt(cnt), .o_misalign_err(mis_err), .o_sel_err(sel_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic compare_out();
    exp_t e;
    if (sb.size() == 0) begin
      n_tests++;
      n_fail++;
      $error("FAIL sb_empty observed=0 expected=1");
    end else begin
      e = sb.pop_front();
      chk("pcF", pcF, e.pcF);
      chk("pcD", pcD, e.pcD);
      chk("pcD2", pcD2, e.pcD2);
      chk("pcX", pcX, e.pcX);
      chk("valid", {28'd0, vF, vD, vD2, vX}, {28'd0, e.v});
      chk("cnt", {28'd0, cnt}, {28'd0, e.cnt});
      chk("misalign_err", {31'd0, mis_err}, {31'd0, e.mis});
      chk("sel_err", {31'd0, sel_err}, {31'd0, e.sel});
      m = e;
    end
  endtask

  task automatic reset_step();
    exp_t e;
    rst = 1'b1; stall = 1'b0; pc_sel = 3'd0; kd = 0; kd2 = 0; kx = 0;
    e.pcF = 32'h100; e.pcD = 0; e.pcD2 = 0; e.pcX = 0;
    e.v = 4'b0000; e.cnt = '0; e.mis = 1'b0; e.sel = 1'b0;
    sb.push_back(e);
    @(posedge clk); #1;
    compare_out();
  endtask

  task automatic step(input logic [2:0] sel, input logic st, input logic k_d, input logic k_d2,
                      input logic k_x, input logic [31:0] imf, input logic [31:0] imd2,
                      input logic [31:0] alu);
    exp_t e;
    logic [31:0] tgt;
    logic redir, adv;
    rst = 1'b0; stall = st; pc_sel = sel; kd = k_d; kd2 = k_d2; kx = k_x;
    immF = imf; immD2 = imd2; alu_x = alu;
    case (sel)
      3'd1:    tgt = m.pcF + imf;
      3'd2:    tgt = {alu[31:1], 1'b0};
      3'd3:    tgt = m.pcD2 + imd2;
      3'd4:    tgt = m.pcD2 + 32'd4;
      default: tgt = m.pcF + 32'd4;
    endcase
    redir = (sel >= 3'd2) && (sel <= 3'd4);
    adv   = redir || !st;
    e = m;
    e.v[3] = 1'b1;
    e.pcX  = m.pcD2;
    e.v[0] = m.v[1] & ~k_x;
    if (adv) begin
      e.pcF  = {tgt[31:2], 2'b00};
      e.pcD  = m.pcF;
      e.pcD2 = m.pcD;
      e.v[2] = m.v[3] & ~k_d;
      e.v[1] = m.v[2] & ~k_d2;
      if (tgt[1:0] != 2'b00) e.mis = 1'b1;
    end else begin
      e.v[1] = 1'b0;
    end
    if (redir && (m.cnt != {CW{1'b1}})) e.cnt = m.cnt + 1'b1;
    if (sel > 3'd4) e.sel = 1'b1;
    sb.push_back(e);
    @(posedge clk); #1;
    compare_out();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; stall = 0; pc_sel = 0; kd = 0; kd2 = 0; kx = 0;
    immF = 0; immD2 = 0; alu_x = 0;

    // 1: reset then sequential fill
    repeat (3) reset_step();
    chk("t1_reset_pcF", pcF, 32'h100);
    chk("t1_reset_valid", {28'd0, vF, vD, vD2, vX}, 32'h0);
    step(3'd0, 0, 0, 0, 0, 0, 0, 0);
    step(3'd0, 0, 0, 0, 0, 0, 0, 0);
    chk("t1_pcF_2", pcF, 32'h108);
    step(3'd0, 0, 0, 0, 0, 0, 0, 0);
    step(3'd0, 0, 0, 0, 0, 0, 0, 0);
    chk("t1_valid_full", {28'd0, vF, vD, vD2, vX}, 32'hF);

    // 2: F-stage immediate jump
    step(3'd2, 0, 0, 0, 0, 0, 0, 32'h200);
    step(3'd1, 0, 0, 0, 0, 32'h40, 0, 0);
    chk("t2_pcF", pcF, 32'h240);
    chk("t2_valid", {28'd0, vF, vD, vD2, vX}, 32'hF);

    // 3: taken branch in D2 with negative immediate
    step(3'd2, 0, 0, 0, 0, 0, 0, 32'h300);
    step(3'd0, 0, 0, 0, 0, 0, 0, 0);
    step(3'd0, 0, 0, 0, 0, 0, 0, 0);
    chk("t3_pcD2_pre", pcD2, 32'h300);
    step(3'd3, 0, 1, 1, 0, 0, 32'hFFFF_FFF8, 0);
    chk("t3_pcF", pcF, 32'h2F8);
    chk("t3_valid", {28'd0, vF, vD, vD2, vX}, 32'h9);

    // 4: JALR with odd target and all kills
    step(3'd2, 0, 1, 1, 1, 0, 0, 32'h1235);
    chk("t4_pcF", pcF, 32'h1234);
    chk("t4_valid", {28'd0, vF, vD, vD2, vX}, 32'h8);
    chk("t4_cnt", {28'd0, cnt}, 32'd4);

    // 5: redirect beats stall, then plain stall
    step(3'd2, 0, 0, 0, 0, 0, 0, 32'h400);
    step(3'd0, 0, 0, 0, 0, 0, 0, 0);
    step(3'd0, 0, 0, 0, 0, 0, 0, 0);
    step(3'd4, 1, 0, 0, 0, 0, 0, 0);
    chk("t5_pcF_redir", pcF, 32'h404);
    chk("t5_pcD_redir", pcD, 32'h408);
    step(3'd0, 1, 0, 0, 0, 0, 0, 0);
    chk("t5_pcF_stall", pcF, 32'h404);
    chk("t5_pcD_stall", pcD, 32'h408);
    chk("t5_validD2_stall", {31'd0, vD2}, 32'd0);

    // 6: sticky error flags, cleared by reset
    step(3'd6, 0, 0, 0, 0, 0, 0, 0);
    chk("t6_sel_err", {31'd0, sel_err}, 32'd1);
    chk("t6_pcF_seq", pcF, 32'h408);
    step(3'd1, 0, 0, 0, 0, 32'h2, 0, 0);
    chk("t6_misalign", {31'd0, mis_err}, 32'd1);
    chk("t6_pcF_aligned", pcF, 32'h408);
    step(3'd0, 0, 0, 0, 0, 0, 0, 0);
    chk("t6_sticky", {30'd0, mis_err, sel_err}, 32'd3);
    reset_step();
    chk("t6_rst_clear", {30'd0, mis_err, sel_err}, 32'd0);

    // redirect counter saturation
    for (int i = 0; i < 18; i++) step(3'd4, 0, 0, 0, 0, 0, 0, 0);
    chk("sat_cnt", {28'd0, cnt}, 32'hF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
